// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: control-word field map and default latencies that the decoder and issue logic share
package cpu_ctrl_pkg;
  localparam int unsigned RS_LO      = 27;
  localparam int unsigned RT_LO      = 22;
  localparam int unsigned RD_LO      = 17;
  localparam int unsigned IMM_BIT    = 16;
  localparam int unsigned ALU_OP_LO  = 13;
  localparam int unsigned MEM_WR_BIT = 12;
  localparam int unsigned MEM_AC_BIT = 11;
  localparam int unsigned REG_WR_BIT = 10;
  localparam int unsigned MUL_BIT    = 9;
  localparam int unsigned ALU_LAT_DEF = 3;
  localparam int unsigned LD_LAT_DEF  = 4;
  localparam int unsigned MUL_LAT_DEF = 6;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       imm;
    logic       rsv15;
    alu_op_e    alu_op;
    logic       mem_wr;
    logic       mem_acc;
    logic       reg_wr;
    logic       mul;
    logic [8:0] rsv;
  } ctrl_t;
  function automatic logic [2:0] lat_of(input logic mul, input logic mem_acc,
                                        input logic [2:0] alu, input logic [2:0] ld,
                                        input logic [2:0] mu);
    return mul ? mu : mem_acc ? ld : alu;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register remaining-latency counters, busy lookups, write-port clash and retire detect
module reg_scoreboard
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic [4:0] i_rd,
  input  logic [2:0] i_lat,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output logic       o_rs_busy,
  output logic       o_rt_busy,
  output logic       o_rd_busy,
  output logic       o_clash,
  output logic       o_ret,
  output logic [4:0] o_ret_rd
);
  logic [2:0] r_cnt [32];
  logic [2:0] w_lat_p1;
  assign w_lat_p1  = i_lat + 3'd1;
  assign o_rs_busy = r_cnt[i_rs] != 3'd0;
  assign o_rt_busy = r_cnt[i_rt] != 3'd0;
  assign o_rd_busy = r_cnt[i_rd] != 3'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= 3'd0;
    end else begin
      for (int i = 1; i < 32; i++)
        r_cnt[i] <= (i_set && i_rd == 5'(i)) ? i_lat :
                    (r_cnt[i] != 3'd0) ? r_cnt[i] - 3'd1 : 3'd0;
    end
  end
  // a count of L+1 would reach zero on the same edge as a new writer of latency L
  always_comb begin
    o_clash  = 1'b0;
    o_ret    = 1'b0;
    o_ret_rd = 5'd0;
    for (int i = 1; i < 32; i++) begin
      o_clash  = o_clash | (r_cnt[i] == w_lat_p1);
      o_ret    = o_ret | (r_cnt[i] == 3'd1);
      o_ret_rd = (r_cnt[i] == 3'd1) ? 5'(i) : o_ret_rd;
    end
  end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order single-issue gate with RAW/WAW/write-port/multiplier hazard stalls
module issue_scheduler
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LAT = ALU_LAT_DEF,
  parameter int unsigned LD_LAT  = LD_LAT_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [31:0] dec_ctrl,
  output logic        dec_ready,
  output logic        iss_valid,
  output logic [31:0] iss_ctrl,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        mul_busy,
  output logic [15:0] stall_cycles
);
  logic [4:0]  w_rs, w_rt, w_rd;
  logic        w_mul, w_writer, w_issue;
  logic [2:0]  w_lat;
  logic        w_rs_busy, w_rt_busy, w_rd_busy, w_clash, w_ret;
  logic [4:0]  w_ret_rd;
  logic [2:0]  r_mul_cnt;
  logic        r_iss_valid, r_wb_valid;
  logic [31:0] r_iss_ctrl;
  logic [4:0]  r_wb_rd;
  logic [15:0] r_stall;
  assign w_rs     = dec_ctrl[RS_LO +: 5];
  assign w_rt     = dec_ctrl[RT_LO +: 5];
  assign w_rd     = dec_ctrl[RD_LO +: 5];
  assign w_mul    = dec_ctrl[MUL_BIT];
  assign w_writer = dec_ctrl[REG_WR_BIT] && w_rd != 5'd0;
  assign w_lat    = lat_of(w_mul, dec_ctrl[MEM_AC_BIT], 3'(ALU_LAT), 3'(LD_LAT), 3'(MUL_LAT));
  assign mul_busy = r_mul_cnt != 3'd0;
  assign dec_ready = !rst && !w_rs_busy && !w_rt_busy
                     && !(w_writer && (w_rd_busy || w_clash))
                     && !(w_mul && mul_busy);
  assign w_issue  = dec_valid && dec_ready;
  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_set    (w_issue && w_writer),
    .i_rd     (w_rd),
    .i_lat    (w_lat),
    .i_rs     (w_rs),
    .i_rt     (w_rt),
    .o_rs_busy(w_rs_busy),
    .o_rt_busy(w_rt_busy),
    .o_rd_busy(w_rd_busy),
    .o_clash  (w_clash),
    .o_ret    (w_ret),
    .o_ret_rd (w_ret_rd)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_ctrl  <= 32'd0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_mul_cnt   <= 3'd0;
      r_stall     <= 16'd0;
    end else begin
      r_iss_valid <= w_issue;
      r_iss_ctrl  <= w_issue ? dec_ctrl : r_iss_ctrl;
      r_wb_valid  <= w_ret;
      r_wb_rd     <= w_ret_rd;
      r_mul_cnt   <= (w_issue && w_mul) ? 3'(MUL_LAT) : mul_busy ? r_mul_cnt - 3'd1 : 3'd0;
      r_stall     <= (dec_valid && !dec_ready && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall;
    end
  end
  assign iss_valid    = r_iss_valid;
  assign iss_ctrl     = r_iss_ctrl;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign stall_cycles = r_stall;
endmodule
